// File: rtl/e203_itcm_pkg.sv
// ---------------------------------------------------------------------------
// e203_itcm_pkg
//   Shared constants and types for the ITCM narrow-to-wide ICB adapter.
//   ITCM_DW        : ITCM data width (64)
//   ICB_NARROW_DW  : requester-side ICB data width (32)
//   LANE_SEL_BIT   : byte-address bit that picks the 32-bit half of a 64-bit word
//   lane_t         : which half (lower/upper) a narrow access maps to
// ---------------------------------------------------------------------------
package e203_itcm_pkg;

    localparam int ITCM_DW       = 64;
    localparam int ICB_NARROW_DW = 32;
    localparam int NARROW_MW     = ICB_NARROW_DW / 8;
    localparam int ITCM_MW       = ITCM_DW / 8;
    localparam int LANE_SEL_BIT  = 2;

    typedef enum logic {
        LANE_LO = 1'b0,
        LANE_HI = 1'b1
    } lane_t;

    // Place a narrow byte mask into the selected half of the wide mask.
    function automatic logic [ITCM_MW-1:0] steer_mask(input lane_t lane,
                                                      input logic [NARROW_MW-1:0] mask);
        logic [ITCM_MW-1:0] res;
        res = '0;
        if (lane == LANE_HI) begin
            res[ITCM_MW-1:NARROW_MW] = mask;
        end else begin
            res[NARROW_MW-1:0] = mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/e203_itcm_n2w_lane_fifo.sv
// ---------------------------------------------------------------------------
// e203_itcm_n2w_lane_fifo
//   In-order record of the lane of each outstanding command. Depth need not be
//   a power of two; pointers wrap explicitly at DEPTH-1.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset (flushes contents)
//     push        : write push_lane at the tail (ignored when full)
//     push_lane   : lane of the command being accepted
//     pop         : drop the head entry (ignored when empty)
//     head_lane   : lane at the head; LANE_LO when empty
//     full, empty : occupancy flags
//     count       : number of stored entries
// ---------------------------------------------------------------------------
module e203_itcm_n2w_lane_fifo
    import e203_itcm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  lane_t                          push_lane,
    input  logic                           pop,
    output lane_t                          head_lane,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    lane_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_en;
    logic            pop_en;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    // An empty FIFO presents the lower lane so a stray response is harmless.
    assign head_lane = empty ? LANE_LO : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_lane;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/e203_itcm_icb_n2w.sv
// ---------------------------------------------------------------------------
// e203_itcm_icb_n2w
//   Narrow (32-bit) to wide (64-bit) ICB adapter in front of the ITCM
//   controller. Write data is replicated to both halves and the byte mask is
//   steered by address bit 2; the lane of each outstanding command is queued
//   so the matching half of each wide read response is returned in order.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     n_icb_cmd_*         : narrow command channel (from requester)
//     n_icb_rsp_*         : narrow response channel (to requester)
//     w_icb_cmd_*         : wide command channel (to ITCM controller)
//     w_icb_rsp_*         : wide response channel (from ITCM controller)
//     n2w_idle            : high when no command is outstanding
// ---------------------------------------------------------------------------
module e203_itcm_icb_n2w
    import e203_itcm_pkg::*;
#(
    parameter int AW         = 16,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      n_icb_cmd_valid,
    output logic                      n_icb_cmd_ready,
    input  logic [AW-1:0]             n_icb_cmd_addr,
    input  logic                      n_icb_cmd_read,
    input  logic [ICB_NARROW_DW-1:0]  n_icb_cmd_wdata,
    input  logic [NARROW_MW-1:0]      n_icb_cmd_wmask,

    output logic                      n_icb_rsp_valid,
    input  logic                      n_icb_rsp_ready,
    output logic [ICB_NARROW_DW-1:0]  n_icb_rsp_rdata,
    output logic                      n_icb_rsp_err,

    output logic                      w_icb_cmd_valid,
    input  logic                      w_icb_cmd_ready,
    output logic [AW-1:0]             w_icb_cmd_addr,
    output logic                      w_icb_cmd_read,
    output logic [ITCM_DW-1:0]        w_icb_cmd_wdata,
    output logic [ITCM_MW-1:0]        w_icb_cmd_wmask,

    input  logic                      w_icb_rsp_valid,
    output logic                      w_icb_rsp_ready,
    input  logic [ITCM_DW-1:0]        w_icb_rsp_rdata,
    input  logic                      w_icb_rsp_err,

    output logic                      n2w_idle
);

    localparam int CW = $clog2(OUTS_DEPTH+1);

    lane_t           cmd_lane;
    lane_t           head_lane;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            cmd_hs;
    logic            rsp_hs;

    assign cmd_lane = lane_t'(n_icb_cmd_addr[LANE_SEL_BIT]);

    // Command path
    assign w_icb_cmd_valid = n_icb_cmd_valid & ~fifo_full & ~rst;
    assign n_icb_cmd_ready = w_icb_cmd_ready & ~fifo_full & ~rst;
    assign w_icb_cmd_addr  = n_icb_cmd_addr;
    assign w_icb_cmd_read  = n_icb_cmd_read;
    assign w_icb_cmd_wdata = {n_icb_cmd_wdata, n_icb_cmd_wdata};
    assign w_icb_cmd_wmask = steer_mask(cmd_lane, n_icb_cmd_wmask);

    // Response path
    assign n_icb_rsp_valid = w_icb_rsp_valid & ~rst;
    assign w_icb_rsp_ready = n_icb_rsp_ready & ~rst;
    assign n_icb_rsp_rdata = (head_lane == LANE_HI) ? w_icb_rsp_rdata[ITCM_DW-1:ICB_NARROW_DW]
                                                    : w_icb_rsp_rdata[ICB_NARROW_DW-1:0];
    assign n_icb_rsp_err   = w_icb_rsp_err;

    assign cmd_hs = w_icb_cmd_valid & w_icb_cmd_ready;
    assign rsp_hs = n_icb_rsp_valid & n_icb_rsp_ready;

    assign n2w_idle = (fifo_count == '0);

    e203_itcm_n2w_lane_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_lane_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_hs),
        .push_lane (cmd_lane),
        .pop       (rsp_hs),
        .head_lane (head_lane),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A wide response with nothing outstanding breaks the ICB protocol.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_icb_rsp_valid && fifo_empty));
        end
    end

endmodule

// File: tb/tb_e203_itcm_icb_n2w.sv
module tb_e203_itcm_icb_n2w;

    localparam int AW    = 16;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            n_icb_cmd_valid;
    logic            n_icb_cmd_ready;
    logic [AW-1:0]   n_icb_cmd_addr;
    logic            n_icb_cmd_read;
    logic [31:0]     n_icb_cmd_wdata;
    logic [3:0]      n_icb_cmd_wmask;
    logic            n_icb_rsp_valid;
    logic            n_icb_rsp_ready;
    logic [31:0]     n_icb_rsp_rdata;
    logic            n_icb_rsp_err;
    logic            w_icb_cmd_valid;
    logic            w_icb_cmd_ready;
    logic [AW-1:0]   w_icb_cmd_addr;
    logic            w_icb_cmd_read;
    logic [63:0]     w_icb_cmd_wdata;
    logic [7:0]      w_icb_cmd_wmask;
    logic            w_icb_rsp_valid;
    logic            w_icb_rsp_ready;
    logic [63:0]     w_icb_rsp_rdata;
    logic            w_icb_rsp_err;
    logic            n2w_idle;

    always #5 clk = ~clk;

    e203_itcm_icb_n2w #(
        .AW         (AW),
        .OUTS_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .n_icb_cmd_valid (n_icb_cmd_valid),
        .n_icb_cmd_ready (n_icb_cmd_ready),
        .n_icb_cmd_addr  (n_icb_cmd_addr),
        .n_icb_cmd_read  (n_icb_cmd_read),
        .n_icb_cmd_wdata (n_icb_cmd_wdata),
        .n_icb_cmd_wmask (n_icb_cmd_wmask),
        .n_icb_rsp_valid (n_icb_rsp_valid),
        .n_icb_rsp_ready (n_icb_rsp_ready),
        .n_icb_rsp_rdata (n_icb_rsp_rdata),
        .n_icb_rsp_err   (n_icb_rsp_err),
        .w_icb_cmd_valid (w_icb_cmd_valid),
        .w_icb_cmd_ready (w_icb_cmd_ready),
        .w_icb_cmd_addr  (w_icb_cmd_addr),
        .w_icb_cmd_read  (w_icb_cmd_read),
        .w_icb_cmd_wdata (w_icb_cmd_wdata),
        .w_icb_cmd_wmask (w_icb_cmd_wmask),
        .w_icb_rsp_valid (w_icb_rsp_valid),
        .w_icb_rsp_ready (w_icb_rsp_ready),
        .w_icb_rsp_rdata (w_icb_rsp_rdata),
        .w_icb_rsp_err   (w_icb_rsp_err),
        .n2w_idle        (n2w_idle)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: lanes (address bit 2) of outstanding commands, oldest first.
    bit lane_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic          read;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        logic [63:0]   exp_wdata;
        logic [7:0]    exp_wmask;
    } steer_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag);
        int unsigned sz;
        logic        full_now;
        logic        head_hi;
        logic [7:0]  exp_mask;
        logic [31:0] exp_rdata;
        sz        = lane_q.size();
        full_now  = (sz >= DEPTH);
        head_hi   = (sz != 0) ? lane_q[0] : 1'b0;
        exp_mask  = {4'h0, n_icb_cmd_wmask};
        if (n_icb_cmd_addr[2]) exp_mask = exp_mask << 4;
        exp_rdata = head_hi ? w_icb_rsp_rdata[63:32] : w_icb_rsp_rdata[31:0];
        chk({tag, ".w_cmd_valid"}, w_icb_cmd_valid, n_icb_cmd_valid && !full_now && !rst);
        chk({tag, ".n_cmd_ready"}, n_icb_cmd_ready, w_icb_cmd_ready && !full_now && !rst);
        chk({tag, ".w_cmd_addr"},  w_icb_cmd_addr,  n_icb_cmd_addr);
        chk({tag, ".w_cmd_read"},  w_icb_cmd_read,  n_icb_cmd_read);
        chk({tag, ".w_cmd_wdata"}, w_icb_cmd_wdata, {n_icb_cmd_wdata, n_icb_cmd_wdata});
        chk({tag, ".w_cmd_wmask"}, w_icb_cmd_wmask, exp_mask);
        chk({tag, ".n_rsp_valid"}, n_icb_rsp_valid, w_icb_rsp_valid && !rst);
        chk({tag, ".w_rsp_ready"}, w_icb_rsp_ready, n_icb_rsp_ready && !rst);
        chk({tag, ".n_rsp_rdata"}, n_icb_rsp_rdata, exp_rdata);
        chk({tag, ".n_rsp_err"},   n_icb_rsp_err,   w_icb_rsp_err);
        chk({tag, ".idle"},        n2w_idle,        sz == 0);
    endtask

    // Advance one clock and update the model from the handshakes it predicts.
    task automatic step();
        bit cmd_hs;
        bit rsp_hs;
        bit lane;
        cmd_hs = !rst && n_icb_cmd_valid && w_icb_cmd_ready && (lane_q.size() < DEPTH);
        rsp_hs = !rst && w_icb_rsp_valid && n_icb_rsp_ready && (lane_q.size() != 0);
        lane   = n_icb_cmd_addr[2];
        @(posedge clk);
        if (rst) begin
            lane_q.delete();
        end else begin
            if (rsp_hs) void'(lane_q.pop_front());
            if (cmd_hs) lane_q.push_back(lane);
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        step();
    endtask

    task automatic idle_inputs();
        n_icb_cmd_valid = 1'b0;
        n_icb_cmd_addr  = '0;
        n_icb_cmd_read  = 1'b1;
        n_icb_cmd_wdata = '0;
        n_icb_cmd_wmask = 4'hF;
        w_icb_cmd_ready = 1'b1;
        w_icb_rsp_valid = 1'b0;
        n_icb_rsp_ready = 1'b1;
        w_icb_rsp_rdata = '0;
        w_icb_rsp_err   = 1'b0;
    endtask

    task automatic send_read(input logic [AW-1:0] addr, input string tag);
        idle_inputs();
        n_icb_cmd_valid = 1'b1;
        n_icb_cmd_addr  = addr;
        #1;
        chk({tag, ".accept"}, n_icb_cmd_ready, 1'b1);
        cycle(tag);
    endtask

    task automatic send_rsp(input logic [63:0] rdata, input logic [31:0] exp, input string tag);
        idle_inputs();
        w_icb_rsp_valid = 1'b1;
        w_icb_rsp_rdata = rdata;
        #1;
        chk({tag, ".rdata"}, n_icb_rsp_rdata, exp);
        cycle(tag);
    endtask

    steer_vec_t vecs [6];

    initial begin
        vecs[0] = '{16'h0008, 1'b0, 32'hDEADBEEF, 4'b0011, 64'hDEADBEEF_DEADBEEF, 8'h03};
        vecs[1] = '{16'h000C, 1'b0, 32'hDEADBEEF, 4'b0011, 64'hDEADBEEF_DEADBEEF, 8'h30};
        vecs[2] = '{16'h0000, 1'b1, 32'h00000000, 4'b1111, 64'h0,                 8'h0F};
        vecs[3] = '{16'h0004, 1'b1, 32'h00000000, 4'b1111, 64'h0,                 8'hF0};
        vecs[4] = '{16'h1234, 1'b0, 32'h12345678, 4'b0101, 64'h12345678_12345678, 8'h50};
        vecs[5] = '{16'hFFF8, 1'b0, 32'hCAFEF00D, 4'b1010, 64'hCAFEF00D_CAFEF00D, 8'h0A};

        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset: handshake outputs held low even with requests pending.
        n_icb_cmd_valid = 1'b1;
        w_icb_rsp_valid = 1'b0;
        #1;
        chk("reset.w_cmd_valid", w_icb_cmd_valid, 1'b0);
        chk("reset.n_cmd_ready", n_icb_cmd_ready, 1'b0);
        chk("reset.w_rsp_ready", w_icb_rsp_ready, 1'b0);
        cycle("reset");
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("reset.idle", n2w_idle, 1'b1);
        chk("reset.ready_after", n_icb_cmd_ready, 1'b1);

        // Steering table: commands held with w_cmd_ready low so none are accepted.
        foreach (vecs[i]) begin
            idle_inputs();
            w_icb_cmd_ready = 1'b0;
            n_icb_cmd_valid = 1'b1;
            n_icb_cmd_addr  = vecs[i].addr;
            n_icb_cmd_read  = vecs[i].read;
            n_icb_cmd_wdata = vecs[i].wdata;
            n_icb_cmd_wmask = vecs[i].wmask;
            #1;
            chk($sformatf("steer%0d.wmask", i), w_icb_cmd_wmask, vecs[i].exp_wmask);
            chk($sformatf("steer%0d.wdata", i), w_icb_cmd_wdata, vecs[i].exp_wdata);
            chk($sformatf("steer%0d.valid", i), w_icb_cmd_valid, 1'b1);
            cycle($sformatf("steer%0d", i));
        end

        // Read lane selection
        send_read(16'h0004, "lane_hi_cmd");
        send_rsp(64'h1111_2222_3333_4444, 32'h1111_2222, "lane_hi_rsp");
        send_read(16'h0000, "lane_lo_cmd");
        send_rsp(64'h1111_2222_3333_4444, 32'h3333_4444, "lane_lo_rsp");

        // Full stall, ordering and pointer wrap
        send_read(16'h0004, "ord_cmd0");
        send_read(16'h0000, "ord_cmd1");
        idle_inputs();
        n_icb_cmd_valid = 1'b1;
        n_icb_cmd_addr  = 16'h0004;
        #1;
        chk("full.n_cmd_ready", n_icb_cmd_ready, 1'b0);
        chk("full.w_cmd_valid", w_icb_cmd_valid, 1'b0);
        chk("full.idle", n2w_idle, 1'b0);
        cycle("full_stall");
        w_icb_rsp_valid = 1'b1;
        w_icb_rsp_rdata = 64'hAAAA_AAAA_5555_5555;
        #1;
        chk("full.still_blocked", n_icb_cmd_ready, 1'b0);
        chk("ord.rdata0", n_icb_rsp_rdata, 32'hAAAA_AAAA);
        cycle("full_pop");
        w_icb_rsp_valid = 1'b0;
        #1;
        chk("full.accept_next", n_icb_cmd_ready, 1'b1);
        cycle("ord_cmd2");
        send_rsp(64'hAAAA_AAAA_5555_5555, 32'h5555_5555, "ord.rdata1");
        send_rsp(64'hAAAA_AAAA_5555_5555, 32'hAAAA_AAAA, "ord.rdata2");
        #1;
        chk("ord.idle_end", n2w_idle, 1'b1);

        // Simultaneous push/pop at one outstanding
        send_read(16'h0004, "pp_cmd0");
        idle_inputs();
        n_icb_cmd_valid = 1'b1;
        n_icb_cmd_addr  = 16'h0000;
        w_icb_rsp_valid = 1'b1;
        w_icb_rsp_rdata = 64'hAAAA_AAAA_5555_5555;
        #1;
        chk("pp.ready", n_icb_cmd_ready, 1'b1);
        chk("pp.rdata_pop", n_icb_rsp_rdata, 32'hAAAA_AAAA);
        cycle("pp_both");
        idle_inputs();
        #1;
        chk("pp.idle", n2w_idle, 1'b0);
        send_rsp(64'hAAAA_AAAA_5555_5555, 32'h5555_5555, "pp.rdata_push");

        // Reset with two outstanding
        send_read(16'h0004, "rst_cmd0");
        send_read(16'h0004, "rst_cmd1");
        idle_inputs();
        rst = 1'b1;
        n_icb_cmd_valid = 1'b1;
        w_icb_rsp_valid = 1'b1;
        w_icb_rsp_rdata = 64'h1111_2222_3333_4444;
        #1;
        chk("midrst.w_cmd_valid", w_icb_cmd_valid, 1'b0);
        chk("midrst.n_cmd_ready", n_icb_cmd_ready, 1'b0);
        chk("midrst.n_rsp_valid", n_icb_rsp_valid, 1'b0);
        chk("midrst.w_rsp_ready", w_icb_rsp_ready, 1'b0);
        cycle("midrst");
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("midrst.idle_after", n2w_idle, 1'b1);
        send_read(16'h0000, "midrst_cmd");
        send_rsp(64'h1111_2222_3333_4444, 32'h3333_4444, "midrst_rsp");

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            n_icb_cmd_valid = 1'($urandom_range(0, 1));
            n_icb_cmd_addr  = AW'($urandom);
            n_icb_cmd_read  = 1'($urandom_range(0, 1));
            n_icb_cmd_wdata = $urandom;
            n_icb_cmd_wmask = 4'($urandom);
            w_icb_cmd_ready = ($urandom_range(0, 3) != 0);
            w_icb_rsp_valid = (lane_q.size() != 0) && ($urandom_range(0, 2) != 0);
            n_icb_rsp_ready = ($urandom_range(0, 3) != 0);
            w_icb_rsp_rdata = {$urandom, $urandom};
            w_icb_rsp_err   = 1'($urandom_range(0, 1));
            cycle("rand");
        end
        rst = 1'b0;
        idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
